flasher_run_arbiter: RTL and testbench
======================================

Name: flasher_run_arbiter

Overview:
- Shares one 16-LED bound-flasher engine among NREQ requesters (buttons, host registers, test hooks).
- Arbitrates requests round-robin and launches one run per grant by pulsing the engine's flick input.
- Tracks run completion from the engine's LED bus; on a hang, resets the engine and flags an error.
- Sits between the requester logic and the flasher engine in the LED subsystem.

Parameters:
NREQ, 3, number of requesters (2..8)
FLICK_CYCLES, 2, cycles flick_o is held high at run start (1..15)
TIMEOUT, 256, max cycles from run launch to completion before abort (>= 8, fits in 16-bit counter)
ABORT_RST_CYCLES, 2, cycles flasher_rst_n_o is held low on abort (1..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester run request, level, sampled only in IDLE
gnt  output  NREQ  one-hot grant, held for the whole run, including its DONE/ABORT cycle(s)
done  output  NREQ  one-cycle completion pulse to the granted requester
leds_i  input  16  LED bus from the flasher engine
flick_o  output  1  flick to the engine
flasher_rst_n_o  output  1  active-low reset to the engine
busy  output  1  high in every state except IDLE
timeout_err  output  1  sticky abort flag
err_clr  input  1  clears timeout_err

Behaviour:
- All outputs are registered. Reset values: gnt=0, done=0, flick_o=0, flasher_rst_n_o=0, busy=0, timeout_err=0. Internal reset values: state=IDLE, last_grant=NREQ-1, counters=0, seen_full=0.
- flasher_rst_n_o rises on the first clk edge after reset releases, and stays 1 except during ABORT.
- States: IDLE, FLICK, RUN, DONE, ABORT.
- IDLE:
  - If req != 0 and flasher_rst_n_o=1, grant the first set bit searching from last_grant+1 with wrap-around.
  - Next edge: gnt=onehot(winner), flick_o=1, busy=1, tmo_cnt=0, seen_full=0, go FLICK.
  - Latency: req sampled at edge k gives gnt and flick_o high after edge k.
- FLICK:
  - flick_o stays 1 for exactly FLICK_CYCLES cycles, then drops to 0; go RUN.
- RUN:
  - Set seen_full when leds_i==16'hFFFF.
  - When seen_full=1 and leds_i==16'h0000, go DONE.
  - leds_i==0 before seen_full is ignored; this covers the intermediate all-off points of the sequence.
- tmo_cnt increments every cycle in FLICK and RUN.
  - When tmo_cnt==TIMEOUT-1 and completion is not detected that cycle, go ABORT.
  - Completion and timeout in the same cycle: completion wins.
- DONE (1 cycle):
  - done[winner]=1.
  - Next edge: gnt=0, done=0, busy=0, last_grant=winner, go IDLE.
  - A new grant needs at least one IDLE cycle, so there is no back-to-back grant without a gap.
- ABORT:
  - flick_o=0, flasher_rst_n_o=0 for ABORT_RST_CYCLES cycles.
  - timeout_err set on entry.
  - On the last ABORT cycle: done[winner]=1.
  - Next edge: flasher_rst_n_o=1, gnt=0, last_grant=winner, go IDLE.
- req deasserted while granted: ignored, the run completes normally. req still high after done: re-arbitrated as a new request.
- err_clr clears timeout_err. If err_clr and an abort set occur in the same cycle, set wins.
- gnt is always one-hot or zero. done is only ever asserted on the bit set in gnt.
- Reset asserted mid-run: immediate return to reset values. The engine is held in reset via flasher_rst_n_o=0, and no done pulse is issued.
- Unknown state encoding: recover to IDLE with outputs at reset values.

Test Plan:
- Single request: NREQ=3, req=3'b010, engine model completes at cycle 70 -> gnt=010 one edge after req, flick_o high 2 cycles, done=010 one cycle, busy low after, timeout_err=0.
- Round robin: req=3'b111 held high -> grants in order 001, 010, 100, 001, with one IDLE cycle between runs and no grant overlap.
- False completion: engine drives leds 0x3F -> 0x0000 (seen_full=0) -> 0xFFFF -> 0x0000 -> DONE only after the second 0x0000.
- Timeout: TIMEOUT=64, engine frozen at 0x001F -> ABORT at tmo_cnt=63, flasher_rst_n_o low 2 cycles, done pulse, timeout_err=1 and stays 1. err_clr=1 for one cycle -> timeout_err=0.
- Simultaneous events: completion on the same cycle tmo_cnt=TIMEOUT-1 -> DONE, timeout_err stays 0. err_clr together with an abort set -> timeout_err=1.
- Reset mid-run: rst_n=1 during RUN -> gnt=0, flick_o=0, flasher_rst_n_o=0, done never pulses. After release, req=001 is granted first (last_grant reset to NREQ-1).

Source files
------------

// File: rtl/flasher_run_arbiter.sv
// Round-robin front end for a shared 16-LED bound-flasher engine.
// Grants one requester at a time, launches a run with a flick pulse, watches
// the LED bus for a full-on then all-off completion, and resets the engine
// with a sticky error flag if a run hangs.
module flasher_run_arbiter #(
    parameter int unsigned NREQ             = 3,
    parameter int unsigned FLICK_CYCLES     = 2,
    parameter int unsigned TIMEOUT          = 256,
    parameter int unsigned ABORT_RST_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    input  logic [15:0]     leds_i,
    output logic            flick_o,
    output logic            flasher_rst_n_o,
    output logic            busy,
    output logic            timeout_err,
    input  logic            err_clr
);

    localparam int unsigned IdxW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]  FlickLast = 4'(FLICK_CYCLES - 1);
    localparam logic [3:0]  AbortLast = 4'(ABORT_RST_CYCLES - 1);
    localparam logic [15:0] TmoLast   = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFlick = 3'd1,
        StRun   = 3'd2,
        StDone  = 3'd3,
        StAbort = 3'd4
    } state_e;

    state_e          state_q;
    logic [IdxW-1:0] last_grant_q;
    logic [IdxW-1:0] winner_q;
    logic [15:0]     tmo_cnt_q;
    // Shared cycle counter: flick length in FLICK, engine-reset length in ABORT.
    logic [3:0]      phase_cnt_q;
    logic            seen_full_q;

    logic [IdxW-1:0] arb_idx;
    logic [IdxW-1:0] cand_idx;
    logic            arb_found;
    logic            run_complete;
    logic            timeout_hit;
    logic            abort_set;

    // Round-robin pick: first requester after the last winner, with wrap-around.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand_idx = IdxW'((32'(last_grant_q) + i) % NREQ);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Completion / hang detection for the current run.
    always_comb begin
        // An all-off bus only counts once the run has been fully lit.
        run_complete = (state_q == StRun) && seen_full_q && (leds_i == 16'h0000);
        timeout_hit  = ((state_q == StFlick) || (state_q == StRun)) && (tmo_cnt_q == TmoLast);
        // Completion beats timeout when both land on the same cycle.
        abort_set    = timeout_hit && !run_complete;
    end

    // Run controller: state, counters and every registered output.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q         <= StIdle;
            last_grant_q    <= IdxW'(NREQ - 1);
            winner_q        <= '0;
            tmo_cnt_q       <= '0;
            phase_cnt_q     <= '0;
            seen_full_q     <= 1'b0;
            gnt             <= '0;
            done            <= '0;
            flick_o         <= 1'b0;
            flasher_rst_n_o <= 1'b0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            // Setting the flag outranks a clear in the same cycle.
            timeout_err <= abort_set | (timeout_err & ~err_clr);

            case (state_q)
                StIdle: begin
                    flasher_rst_n_o <= 1'b1;
                    done            <= '0;
                    // Wait for the engine to be out of reset before launching.
                    if (arb_found && flasher_rst_n_o) begin
                        gnt         <= NREQ'(1) << arb_idx;
                        winner_q    <= arb_idx;
                        flick_o     <= 1'b1;
                        busy        <= 1'b1;
                        tmo_cnt_q   <= '0;
                        phase_cnt_q <= '0;
                        seen_full_q <= 1'b0;
                        state_q     <= StFlick;
                    end
                end

                StFlick: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    if (abort_set) begin
                        flick_o         <= 1'b0;
                        flasher_rst_n_o <= 1'b0;
                        phase_cnt_q     <= '0;
                        done            <= (AbortLast == 4'd0) ? gnt : '0;
                        state_q         <= StAbort;
                    end else if (phase_cnt_q == FlickLast) begin
                        flick_o <= 1'b0;
                        state_q <= StRun;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 4'd1;
                    end
                end

                StRun: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    if (leds_i == 16'hFFFF) begin
                        seen_full_q <= 1'b1;
                    end
                    if (run_complete) begin
                        done    <= gnt;
                        state_q <= StDone;
                    end else if (abort_set) begin
                        flick_o         <= 1'b0;
                        flasher_rst_n_o <= 1'b0;
                        phase_cnt_q     <= '0;
                        done            <= (AbortLast == 4'd0) ? gnt : '0;
                        state_q         <= StAbort;
                    end
                end

                StDone: begin
                    done         <= '0;
                    gnt          <= '0;
                    busy         <= 1'b0;
                    last_grant_q <= winner_q;
                    state_q      <= StIdle;
                end

                StAbort: begin
                    if (phase_cnt_q == AbortLast) begin
                        flasher_rst_n_o <= 1'b1;
                        gnt             <= '0;
                        done            <= '0;
                        busy            <= 1'b0;
                        last_grant_q    <= winner_q;
                        phase_cnt_q     <= '0;
                        state_q         <= StIdle;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 4'd1;
                        // Completion pulse lands on the final engine-reset cycle.
                        if (phase_cnt_q + 4'd1 == AbortLast) begin
                            done <= gnt;
                        end
                    end
                end

                default: begin
                    state_q         <= StIdle;
                    last_grant_q    <= IdxW'(NREQ - 1);
                    winner_q        <= '0;
                    tmo_cnt_q       <= '0;
                    phase_cnt_q     <= '0;
                    seen_full_q     <= 1'b0;
                    gnt             <= '0;
                    done            <= '0;
                    flick_o         <= 1'b0;
                    flasher_rst_n_o <= 1'b0;
                    busy            <= 1'b0;
                    timeout_err     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flasher_run_arbiter.sv
// Directed bench for flasher_run_arbiter with a grant/done scoreboard.
module tb_flasher_run_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned TMO  = 64;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b1;
    logic [NREQ-1:0] req     = '0;
    logic [15:0]     leds_i  = '0;
    logic            err_clr = 1'b0;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            flick_o;
    logic            flasher_rst_n_o;
    logic            busy;
    logic            timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [NREQ-1:0] d;
        logic            err;
    } done_exp_t;

    logic [NREQ-1:0] exp_gnt_q[$];
    done_exp_t       exp_done_q[$];
    logic [15:0]     pat [64];
    logic [NREQ-1:0] prev_gnt = '0;

    flasher_run_arbiter #(
        .NREQ             (NREQ),
        .FLICK_CYCLES     (2),
        .TIMEOUT          (TMO),
        .ABORT_RST_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .gnt             (gnt),
        .done            (done),
        .leds_i          (leds_i),
        .flick_o         (flick_o),
        .flasher_rst_n_o (flasher_rst_n_o),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .err_clr         (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run; pat[0..n-1] is driven on the LED bus once RUN is reached.
    task automatic run_seq(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                           input logic hold, input int n, input logic exp_err);
        done_exp_t e;
        e.d   = w;
        e.err = exp_err;
        exp_gnt_q.push_back(w);
        exp_done_q.push_back(e);
        req = r;
        tick();
        check("grant", 32'(gnt), 32'(w));
        check("flick_start", 32'(flick_o), 1);
        check("busy_start", 32'(busy), 1);
        if (!hold) req = '0;
        tick();
        check("flick_hold", 32'(flick_o), 1);
        tick();
        check("flick_end", 32'(flick_o), 0);
        for (int i = 0; i < n; i++) begin
            leds_i = pat[i];
            tick();
            if (i < n - 1) check("no_early_done", 32'(done), 0);
        end
        check("done_pulse", 32'(done), 32'(w));
        check("gnt_in_done", 32'(gnt), 32'(w));
        leds_i = '0;
        tick();
        check("gnt_released", 32'(gnt), 0);
        check("busy_released", 32'(busy), 0);
        check("done_cleared", 32'(done), 0);
    endtask

    // Run with the engine frozen mid-sequence so the timeout fires.
    task automatic run_timeout(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                               input logic clr_with_set);
        done_exp_t e;
        e.d   = w;
        e.err = 1'b1;
        exp_gnt_q.push_back(w);
        exp_done_q.push_back(e);
        req = r;
        tick();
        check("to_grant", 32'(gnt), 32'(w));
        req    = '0;
        leds_i = 16'h001F;
        repeat (TMO - 1) tick();
        check("to_busy_last", 32'(busy), 1);
        check("to_frst_last", 32'(flasher_rst_n_o), 1);
        check("to_err_before", 32'(timeout_err), 0);
        err_clr = clr_with_set;
        tick();
        err_clr = 1'b0;
        check("abort_frst_low", 32'(flasher_rst_n_o), 0);
        check("abort_err_set", 32'(timeout_err), 1);
        check("abort_no_done_yet", 32'(done), 0);
        check("abort_gnt_held", 32'(gnt), 32'(w));
        check("abort_flick_low", 32'(flick_o), 0);
        tick();
        check("abort_frst_low2", 32'(flasher_rst_n_o), 0);
        check("abort_done", 32'(done), 32'(w));
        tick();
        check("abort_exit_frst", 32'(flasher_rst_n_o), 1);
        check("abort_exit_gnt", 32'(gnt), 0);
        check("abort_exit_busy", 32'(busy), 0);
        check("abort_exit_done", 32'(done), 0);
        check("abort_err_sticky", 32'(timeout_err), 1);
        leds_i = '0;
    endtask

    // Monitor: invariants every cycle, grant/done events against the scoreboard.
    initial begin
        done_exp_t e;
        forever begin
            @(negedge clk);
            check("gnt_onehot0", 32'($onehot0(gnt)), 1);
            check("done_within_gnt", 32'(done & ~gnt), 0);
            if (gnt != '0 && prev_gnt == '0) begin
                if (exp_gnt_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant: actual=%0h required=none", gnt);
                end else begin
                    check("grant_order", 32'(gnt), 32'(exp_gnt_q.pop_front()));
                end
            end
            if (done != '0) begin
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: actual=%0h required=none", done);
                end else begin
                    e = exp_done_q.pop_front();
                    check("done_target", 32'(done), 32'(e.d));
                    check("err_at_done", 32'(timeout_err), 32'(e.err));
                end
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values.
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_flick", 32'(flick_o), 0);
        check("rst_frst", 32'(flasher_rst_n_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(timeout_err), 0);
        rst_n = 1'b0;
        check("frst_before_edge", 32'(flasher_rst_n_o), 0);
        tick();
        check("frst_after_release", 32'(flasher_rst_n_o), 1);
        check("idle_busy", 32'(busy), 0);

        // Single request, ramp up to full then off.
        for (int i = 0; i < 16; i++) pat[i] = 16'hFFFF >> (15 - i);
        pat[16] = 16'h0000;
        run_seq(3'b010, 3'b010, 1'b0, 17, 1'b0);
        check("single_err", 32'(timeout_err), 0);

        // Intermediate all-off before full-on must be ignored.
        pat[0] = 16'h003F;
        pat[1] = 16'h0000;
        pat[2] = 16'hFFFF;
        pat[3] = 16'h0000;
        run_seq(3'b100, 3'b100, 1'b0, 4, 1'b0);

        // Timeout: last_grant=2, req=110 -> 010.
        run_timeout(3'b110, 3'b010, 1'b0);
        tick();
        check("err_still_set", 32'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 32'(timeout_err), 0);

        // Completion on the tmo_cnt==TIMEOUT-1 cycle; last_grant=1, req=101 -> 100.
        for (int i = 0; i < 60; i++) pat[i] = 16'h001F;
        pat[60] = 16'hFFFF;
        pat[61] = 16'h0000;
        run_seq(3'b101, 3'b100, 1'b0, 62, 1'b0);
        check("race_err_clear", 32'(timeout_err), 0);

        // err_clr coincident with abort set; last_grant=2, req=011 -> 001.
        run_timeout(3'b011, 3'b001, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared2", 32'(timeout_err), 0);

        // Reset mid-run; last_grant=0, req=010 -> 010.
        exp_gnt_q.push_back(3'b010);
        req = 3'b010;
        tick();
        check("mid_grant", 32'(gnt), 32'(3'b010));
        req = '0;
        tick();
        tick();
        leds_i = 16'hFFFF;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt), 0);
        check("mid_rst_flick", 32'(flick_o), 0);
        check("mid_rst_frst", 32'(flasher_rst_n_o), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        leds_i = '0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_frst_release", 32'(flasher_rst_n_o), 1);

        // Round robin with all requests held; starts at 001 after reset.
        for (int i = 0; i < 16; i++) pat[i] = 16'hFFFF >> (15 - i);
        pat[16] = 16'h0000;
        run_seq(3'b111, 3'b001, 1'b1, 17, 1'b0);
        run_seq(3'b111, 3'b010, 1'b1, 17, 1'b0);
        run_seq(3'b111, 3'b100, 1'b1, 17, 1'b0);
        run_seq(3'b111, 3'b001, 1'b1, 17, 1'b0);
        req = '0;
        tick();
        tick();
        check("final_idle_busy", 32'(busy), 0);
        check("final_idle_gnt", 32'(gnt), 0);
        check("gnt_queue_empty", exp_gnt_q.size(), 0);
        check("done_queue_empty", exp_done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
